// File: rtl/rd_buf_seg_fetch.sv
// rd_buf_seg_fetch
//   Segmenting fetch engine in front of the read circular-buffer reader.
//   A send command (flow, start offset, byte length) is cut into segments of
//   at most MSS_BYTES. The engine handles one segment at a time. For each
//   segment it issues a read request, then a descriptor to the packetizer,
//   then forwards that segment's payload beats with zero added latency.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_*                    send command in (val/rdy), cmd_done pulse out
//   fetch_rd_buf_req_*       per-segment read request to the buffer reader
//   rd_buf_fetch_req_rdy     reader accepts the request
//   rd_buf_fetch_data_*      payload beats from the reader
//   fetch_rd_buf_data_rdy    payload accept toward the reader
//   seg_meta_*               per-segment descriptor to the packetizer
//   seg_data_*               forwarded payload to the packetizer
//   seg_len_err              sticky flag: beat count disagreed with segment size

`ifndef FLOW_ID_W
`define FLOW_ID_W 8
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 16
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 256
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 5
`endif

module rd_buf_seg_fetch #(
    parameter int BUF_PTR_W = -1,
    parameter int MSS_BYTES = 1460,
    // BUF_PTR_W has no usable default; it must be overridden by the parent.
    localparam int PW = (BUF_PTR_W < 1) ? 1 : BUF_PTR_W
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            cmd_val,
    input  logic [`FLOW_ID_W-1:0]           cmd_flowid,
    input  logic [PW-1:0]                   cmd_offset,
    input  logic [`MSG_DATA_SIZE_WIDTH-1:0] cmd_len,
    output logic                            cmd_rdy,
    output logic                            cmd_done,

    output logic                            fetch_rd_buf_req_val,
    output logic [`FLOW_ID_W-1:0]           fetch_rd_buf_req_flowid,
    output logic [PW-1:0]                   fetch_rd_buf_req_offset,
    output logic [`MSG_DATA_SIZE_WIDTH-1:0] fetch_rd_buf_req_size,
    input  logic                            rd_buf_fetch_req_rdy,

    input  logic                            rd_buf_fetch_data_val,
    input  logic [`MAC_INTERFACE_W-1:0]     rd_buf_fetch_data,
    input  logic                            rd_buf_fetch_data_last,
    input  logic [`MAC_PADBYTES_W-1:0]      rd_buf_fetch_data_padbytes,
    output logic                            fetch_rd_buf_data_rdy,

    output logic                            seg_meta_val,
    output logic [`FLOW_ID_W-1:0]           seg_meta_flowid,
    output logic [PW-1:0]                   seg_meta_offset,
    output logic [`MSG_DATA_SIZE_WIDTH-1:0] seg_meta_size,
    input  logic                            seg_meta_rdy,

    output logic                            seg_data_val,
    output logic [`MAC_INTERFACE_W-1:0]     seg_data,
    output logic                            seg_data_last,
    output logic [`MAC_PADBYTES_W-1:0]      seg_data_padbytes,
    input  logic                            seg_data_rdy,

    output logic                            seg_len_err
);

    localparam int LW         = `MSG_DATA_SIZE_WIDTH;
    localparam int BEAT_BYTES = `MAC_INTERFACE_W / 8;
    localparam logic [LW-1:0] MSS = LW'(MSS_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_META,
        S_DATA,
        S_DONE
    } state_t;

    // Clamp a byte count to one segment.
    function automatic logic [LW-1:0] sat_mss(input logic [LW-1:0] bytes);
        return (bytes > MSS) ? MSS : bytes;
    endfunction

    // Number of bus beats needed to carry a byte count (round up).
    function automatic logic [LW:0] beats_for(input logic [LW-1:0] bytes);
        logic [LW:0] t;
        t = {1'b0, bytes} + (LW+1)'(BEAT_BYTES - 1);
        return t / (LW+1)'(BEAT_BYTES);
    endfunction

    state_t                 state_q, state_d;
    logic [`FLOW_ID_W-1:0]  flowid_q, flowid_d;
    logic [PW-1:0]          cur_offset_q, cur_offset_d;
    logic [LW-1:0]          remaining_q, remaining_d;
    logic [LW-1:0]          seg_size_q, seg_size_d;
    logic [LW:0]            beat_cnt_q, beat_cnt_d;
    logic                   seg_len_err_q, seg_len_err_d;

    logic          in_data;
    logic          cmd_hs, meta_hs, beat_hs, last_hs;
    logic [LW-1:0] remaining_after;
    logic [LW:0]   beat_num;
    logic [LW:0]   exp_beats;

    assign in_data         = (state_q == S_DATA);
    assign cmd_hs          = (state_q == S_IDLE) && cmd_val;
    assign meta_hs         = (state_q == S_META) && seg_meta_rdy;
    assign beat_hs         = in_data && rd_buf_fetch_data_val && seg_data_rdy;
    assign last_hs         = beat_hs && rd_buf_fetch_data_last;
    assign remaining_after = remaining_q - seg_size_q;
    assign beat_num        = beat_cnt_q + 1'b1;
    assign exp_beats       = beats_for(seg_size_q);

    // State register and segment bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            flowid_q      <= '0;
            cur_offset_q  <= '0;
            remaining_q   <= '0;
            seg_size_q    <= '0;
            beat_cnt_q    <= '0;
            seg_len_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flowid_q      <= flowid_d;
            cur_offset_q  <= cur_offset_d;
            remaining_q   <= remaining_d;
            seg_size_q    <= seg_size_d;
            beat_cnt_q    <= beat_cnt_d;
            seg_len_err_q <= seg_len_err_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (cmd_val) state_d = (cmd_len == '0) ? S_DONE : S_REQ;
            S_REQ:  if (rd_buf_fetch_req_rdy) state_d = S_META;
            S_META: if (seg_meta_rdy) state_d = S_DATA;
            S_DATA: if (last_hs) state_d = (remaining_after != '0) ? S_REQ : S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Segment bookkeeping: seg_size is computed whenever REQ is about to be
    // entered so it stays constant across REQ, META and DATA.
    always_comb begin
        flowid_d      = flowid_q;
        cur_offset_d  = cur_offset_q;
        remaining_d   = remaining_q;
        seg_size_d    = seg_size_q;
        beat_cnt_d    = beat_cnt_q;
        seg_len_err_d = seg_len_err_q;

        if (cmd_hs) begin
            flowid_d     = cmd_flowid;
            cur_offset_d = cmd_offset;
            remaining_d  = cmd_len;
            seg_size_d   = sat_mss(cmd_len);
        end

        if (meta_hs) begin
            beat_cnt_d = '0;
        end

        if (beat_hs) begin
            beat_cnt_d = beat_num;
            if (rd_buf_fetch_data_last) begin
                // Offset wraps naturally around the circular buffer.
                cur_offset_d = cur_offset_q + PW'(seg_size_q);
                remaining_d  = remaining_after;
                seg_size_d   = sat_mss(remaining_after);
                if (beat_num != exp_beats) seg_len_err_d = 1'b1;
            end else if (beat_num == exp_beats) begin
                seg_len_err_d = 1'b1;
            end
        end
    end

    // Outputs
    always_comb begin
        cmd_rdy                 = (state_q == S_IDLE);
        cmd_done                = (state_q == S_DONE);

        fetch_rd_buf_req_val    = (state_q == S_REQ);
        fetch_rd_buf_req_flowid = flowid_q;
        fetch_rd_buf_req_offset = cur_offset_q;
        fetch_rd_buf_req_size   = seg_size_q;

        seg_meta_val            = (state_q == S_META);
        seg_meta_flowid         = flowid_q;
        seg_meta_offset         = cur_offset_q;
        seg_meta_size           = seg_size_q;

        // Payload path is a pure wire while in DATA and closed otherwise.
        fetch_rd_buf_data_rdy   = in_data && seg_data_rdy;
        seg_data_val            = in_data && rd_buf_fetch_data_val;
        seg_data                = in_data ? rd_buf_fetch_data : '0;
        seg_data_last           = in_data && rd_buf_fetch_data_last;
        seg_data_padbytes       = in_data ? rd_buf_fetch_data_padbytes : '0;

        seg_len_err             = seg_len_err_q;
    end

endmodule

// File: tb/tb_rd_buf_seg_fetch.sv
// Testbench for rd_buf_seg_fetch: randomized commands and backpressure,
// a behavioural buffer-reader model, and a scoreboard of expected requests,
// descriptors, payload beats and command completions.

`ifndef FLOW_ID_W
`define FLOW_ID_W 8
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 16
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 256
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 5
`endif

module tb_rd_buf_seg_fetch;

    localparam int PTR_W   = 12;
    localparam int MSS     = 1460;
    localparam int BUF_SZ  = 4096;
    localparam int BEAT_B  = `MAC_INTERFACE_W / 8;

    typedef struct {
        logic [`FLOW_ID_W-1:0]           flow;
        logic [PTR_W-1:0]                off;
        logic [`MSG_DATA_SIZE_WIDTH-1:0] size;
    } seg_t;

    typedef struct {
        logic [`MAC_INTERFACE_W-1:0] data;
        logic                        last;
        logic [`MAC_PADBYTES_W-1:0]  pad;
    } beat_t;

    typedef struct {
        bit zero_len;
        int cmd_cyc;
    } done_t;

    logic clk = 1'b0;
    logic rst;
    logic                            cmd_val;
    logic [`FLOW_ID_W-1:0]           cmd_flowid;
    logic [PTR_W-1:0]                cmd_offset;
    logic [`MSG_DATA_SIZE_WIDTH-1:0] cmd_len;
    logic                            cmd_rdy, cmd_done;
    logic                            fetch_rd_buf_req_val;
    logic [`FLOW_ID_W-1:0]           fetch_rd_buf_req_flowid;
    logic [PTR_W-1:0]                fetch_rd_buf_req_offset;
    logic [`MSG_DATA_SIZE_WIDTH-1:0] fetch_rd_buf_req_size;
    logic                            rd_buf_fetch_req_rdy;
    logic                            rd_buf_fetch_data_val;
    logic [`MAC_INTERFACE_W-1:0]     rd_buf_fetch_data;
    logic                            rd_buf_fetch_data_last;
    logic [`MAC_PADBYTES_W-1:0]      rd_buf_fetch_data_padbytes;
    logic                            fetch_rd_buf_data_rdy;
    logic                            seg_meta_val;
    logic [`FLOW_ID_W-1:0]           seg_meta_flowid;
    logic [PTR_W-1:0]                seg_meta_offset;
    logic [`MSG_DATA_SIZE_WIDTH-1:0] seg_meta_size;
    logic                            seg_meta_rdy;
    logic                            seg_data_val;
    logic [`MAC_INTERFACE_W-1:0]     seg_data;
    logic                            seg_data_last;
    logic [`MAC_PADBYTES_W-1:0]      seg_data_padbytes;
    logic                            seg_data_rdy;
    logic                            seg_len_err;

    rd_buf_seg_fetch #(.BUF_PTR_W(PTR_W), .MSS_BYTES(MSS)) dut (
        .clk(clk), .rst(rst),
        .cmd_val(cmd_val), .cmd_flowid(cmd_flowid), .cmd_offset(cmd_offset),
        .cmd_len(cmd_len), .cmd_rdy(cmd_rdy), .cmd_done(cmd_done),
        .fetch_rd_buf_req_val(fetch_rd_buf_req_val),
        .fetch_rd_buf_req_flowid(fetch_rd_buf_req_flowid),
        .fetch_rd_buf_req_offset(fetch_rd_buf_req_offset),
        .fetch_rd_buf_req_size(fetch_rd_buf_req_size),
        .rd_buf_fetch_req_rdy(rd_buf_fetch_req_rdy),
        .rd_buf_fetch_data_val(rd_buf_fetch_data_val),
        .rd_buf_fetch_data(rd_buf_fetch_data),
        .rd_buf_fetch_data_last(rd_buf_fetch_data_last),
        .rd_buf_fetch_data_padbytes(rd_buf_fetch_data_padbytes),
        .fetch_rd_buf_data_rdy(fetch_rd_buf_data_rdy),
        .seg_meta_val(seg_meta_val), .seg_meta_flowid(seg_meta_flowid),
        .seg_meta_offset(seg_meta_offset), .seg_meta_size(seg_meta_size),
        .seg_meta_rdy(seg_meta_rdy),
        .seg_data_val(seg_data_val), .seg_data(seg_data),
        .seg_data_last(seg_data_last), .seg_data_padbytes(seg_data_padbytes),
        .seg_data_rdy(seg_data_rdy),
        .seg_len_err(seg_len_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    seg_t  exp_req[$];
    seg_t  exp_meta[$];
    beat_t exp_data[$];
    done_t exp_done[$];
    beat_t src_q[$];

    bit bp_en      = 0;
    bit short_last = 0;
    bit long_seg   = 0;
    int beats_seen = 0;
    int last_cyc   = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [`MAC_INTERFACE_W-1:0] rand_data();
        logic [`MAC_INTERFACE_W-1:0] d;
        for (int i = 0; i < `MAC_INTERFACE_W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Reader model: produce the beats for an accepted segment request.
    task automatic gen_beats(input int size);
        int nb;
        beat_t b;
        nb = (size + BEAT_B - 1) / BEAT_B;
        if (short_last && nb > 1) begin nb = nb - 1; short_last = 0; end
        else if (long_seg) begin nb = nb + 1; long_seg = 0; end
        for (int i = 1; i <= nb; i++) begin
            b.data = rand_data();
            b.last = (i == nb);
            b.pad  = (i == nb) ? `MAC_PADBYTES_W'((nb * BEAT_B - size) % BEAT_B) : '0;
            src_q.push_back(b);
            exp_data.push_back(b);
        end
    endtask

    // Buffer reader: accepts requests and streams beats, holding each beat
    // valid until it is taken.
    initial begin
        bit s_rst, s_req_hs, s_dat_hs;
        int s_size;
        rd_buf_fetch_req_rdy       = 1'b1;
        rd_buf_fetch_data_val      = 1'b0;
        rd_buf_fetch_data          = '0;
        rd_buf_fetch_data_last     = 1'b0;
        rd_buf_fetch_data_padbytes = '0;
        forever begin
            @(negedge clk);
            s_rst    = rst;
            s_req_hs = fetch_rd_buf_req_val && rd_buf_fetch_req_rdy;
            s_size   = int'(fetch_rd_buf_req_size);
            s_dat_hs = rd_buf_fetch_data_val && fetch_rd_buf_data_rdy;
            @(posedge clk);
            #1;
            if (s_rst) begin
                src_q.delete();
                rd_buf_fetch_data_val = 1'b0;
            end else begin
                if (s_dat_hs) void'(src_q.pop_front());
                if (s_req_hs) gen_beats(s_size);
            end
            if (!rd_buf_fetch_data_val || s_dat_hs || s_rst) begin
                if (src_q.size() > 0 && (!bp_en || $urandom_range(0, 3) != 0)) begin
                    rd_buf_fetch_data_val      = 1'b1;
                    rd_buf_fetch_data          = src_q[0].data;
                    rd_buf_fetch_data_last     = src_q[0].last;
                    rd_buf_fetch_data_padbytes = src_q[0].pad;
                end else begin
                    rd_buf_fetch_data_val = 1'b0;
                end
            end
            rd_buf_fetch_req_rdy = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Packetizer sink readiness
    initial begin
        seg_meta_rdy = 1'b1;
        seg_data_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            seg_meta_rdy = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            seg_data_rdy = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Monitor: compares every handshake against the scoreboard.
    initial begin
        bit   req_wait, meta_wait;
        seg_t req_hold, meta_hold, e;
        beat_t eb;
        done_t ed;
        req_wait  = 0;
        meta_wait = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_wait  = 0;
                meta_wait = 0;
                continue;
            end
            check("one_active", ($countones({fetch_rd_buf_req_val, seg_meta_val,
                  seg_data_val, cmd_done}) <= 1), 1'b1);

            if (req_wait)
                check("req_held", {fetch_rd_buf_req_val, fetch_rd_buf_req_flowid,
                      fetch_rd_buf_req_offset, fetch_rd_buf_req_size},
                      {1'b1, req_hold.flow, req_hold.off, req_hold.size});
            req_hold = '{fetch_rd_buf_req_flowid, fetch_rd_buf_req_offset, fetch_rd_buf_req_size};
            req_wait = fetch_rd_buf_req_val && !rd_buf_fetch_req_rdy;
            if (fetch_rd_buf_req_val && rd_buf_fetch_req_rdy) begin
                if (exp_req.size() == 0) begin
                    check("req_unexpected", 1, 0);
                end else begin
                    e = exp_req.pop_front();
                    check("req_fields", {fetch_rd_buf_req_flowid, fetch_rd_buf_req_offset,
                          fetch_rd_buf_req_size}, {e.flow, e.off, e.size});
                end
            end

            if (meta_wait)
                check("meta_held", {seg_meta_val, seg_meta_flowid, seg_meta_offset, seg_meta_size},
                      {1'b1, meta_hold.flow, meta_hold.off, meta_hold.size});
            meta_hold = '{seg_meta_flowid, seg_meta_offset, seg_meta_size};
            meta_wait = seg_meta_val && !seg_meta_rdy;
            if (seg_meta_val && seg_meta_rdy) begin
                if (exp_meta.size() == 0) begin
                    check("meta_unexpected", 1, 0);
                end else begin
                    e = exp_meta.pop_front();
                    check("meta_fields", {seg_meta_flowid, seg_meta_offset, seg_meta_size},
                          {e.flow, e.off, e.size});
                end
            end

            if (seg_data_val && seg_data_rdy) begin
                beats_seen++;
                if (seg_data_last) last_cyc = cyc;
                if (exp_data.size() == 0) begin
                    check("beat_unexpected", 1, 0);
                end else begin
                    eb = exp_data.pop_front();
                    check("beat_data", seg_data, eb.data);
                    check("beat_last_pad", {seg_data_last, seg_data_padbytes}, {eb.last, eb.pad});
                end
            end

            if (cmd_done) begin
                if (exp_done.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    ed = exp_done.pop_front();
                    check("done_timing", cyc, (ed.zero_len ? ed.cmd_cyc : last_cyc) + 1);
                end
            end
        end
    end

    task automatic flush_sb();
        exp_req.delete();
        exp_meta.delete();
        exp_data.delete();
        exp_done.delete();
    endtask

    // Issue one command and record the segments it should produce.
    task automatic send_cmd(input int flow, input int off, input int len);
        int guard, o, rem, sz;
        @(posedge clk);
        #1;
        cmd_flowid = `FLOW_ID_W'(flow);
        cmd_offset = PTR_W'(off);
        cmd_len    = `MSG_DATA_SIZE_WIDTH'(len);
        cmd_val    = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!cmd_rdy && guard < 2000) begin @(negedge clk); guard++; end
        if (!cmd_rdy) begin
            check("cmd_rdy_timeout", 0, 1);
            cmd_val = 1'b0;
            return;
        end
        o   = off;
        rem = len;
        while (rem > 0) begin
            sz = (rem > MSS) ? MSS : rem;
            exp_req.push_back('{`FLOW_ID_W'(flow), PTR_W'(o), `MSG_DATA_SIZE_WIDTH'(sz)});
            exp_meta.push_back('{`FLOW_ID_W'(flow), PTR_W'(o), `MSG_DATA_SIZE_WIDTH'(sz)});
            o   = (o + sz) % BUF_SZ;
            rem = rem - sz;
        end
        exp_done.push_back('{(len == 0), cyc});
        @(posedge clk);
        #1;
        cmd_val = 1'b0;
        if (len != 0) begin
            @(negedge clk);
            check("req_latency", fetch_rd_buf_req_val, 1'b1);
        end
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (exp_done.size() != 0 && g < 30000) begin @(negedge clk); g++; end
        check("cmd_complete", exp_done.size(), 0);
        check("sb_drained", exp_req.size() + exp_meta.size() + exp_data.size(), 0);
        flush_sb();
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush_sb();
    endtask

    initial begin
        int g;
        rst        = 1'b1;
        cmd_val    = 1'b0;
        cmd_flowid = '0;
        cmd_offset = '0;
        cmd_len    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_rdy_done", {cmd_rdy, cmd_done}, 2'b10);
        check("rst_valids", {fetch_rd_buf_req_val, seg_meta_val, seg_data_val,
              fetch_rd_buf_data_rdy}, 4'b0);
        check("rst_fields", {fetch_rd_buf_req_flowid, fetch_rd_buf_req_offset, fetch_rd_buf_req_size,
              seg_meta_flowid, seg_meta_offset, seg_meta_size}, '0);
        check("rst_err", seg_len_err, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single segment, then multi-segment, wrap-around and zero length.
        send_cmd(3, 'h100, 100);
        wait_done();
        check("err_clean_basic", seg_len_err, 1'b0);
        send_cmd(5, 0, 3000);
        wait_done();
        send_cmd(1, 'hF00, 2000);
        wait_done();
        send_cmd(2, 'h10, 0);
        wait_done();

        // Randomized commands under random backpressure everywhere.
        bp_en = 1;
        for (int i = 0; i < 15; i++) begin
            send_cmd($urandom_range(0, 255), $urandom_range(0, BUF_SZ - 1),
                     ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 4500));
            wait_done();
        end
        bp_en = 0;
        check("err_clean_random", seg_len_err, 1'b0);

        // Early last on a 100-byte segment, then check the flag sticks.
        short_last = 1;
        send_cmd(4, 'h20, 100);
        wait_done();
        check("err_short", seg_len_err, 1'b1);
        send_cmd(4, 'h40, 64);
        wait_done();
        check("err_sticky", seg_len_err, 1'b1);

        // Missing last on the expected beat.
        pulse_reset();
        @(negedge clk);
        check("err_cleared_by_rst", seg_len_err, 1'b0);
        long_seg = 1;
        send_cmd(6, 'h80, 100);
        wait_done();
        check("err_long", seg_len_err, 1'b1);

        // Reset in the middle of a payload stream, then a clean command.
        pulse_reset();
        g = beats_seen;
        send_cmd(7, 0, 3000);
        while (beats_seen < g + 5 && g < 100000) begin @(negedge clk); g = g + 0; end
        pulse_reset();
        @(negedge clk);
        check("midrst_idle", {cmd_rdy, cmd_done, fetch_rd_buf_req_val, seg_meta_val,
              seg_data_val, seg_len_err}, 6'b100000);
        send_cmd(8, 'h80, 200);
        wait_done();
        check("midrst_err_clean", seg_len_err, 1'b0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
    end

endmodule
